// File: rtl/kftvga_text_writer_if.sv
// Character stream handshake between the host and the text writer.
// Transfer happens on a rising edge where char_valid && char_ready.
interface kftvga_text_writer_if;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] char_code;
    logic [7:0] char_color;

    modport master (
        output char_valid,
        output char_code,
        output char_color,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_code,
        input  char_color,
        output char_ready
    );
endinterface

// File: rtl/kftvga_text_writer.sv
// Text-mode VRAM writer: places characters at a hardware cursor, handles
// CR/LF/BS/FF, line wrap, one-row hardware scroll and full-screen clear.
module kftvga_text_writer #(
    parameter int unsigned COLUMNS    = 80,
    parameter int unsigned ROWS       = 60,
    parameter logic [7:0]  FILL_CODE  = 8'h20,
    parameter logic [7:0]  FILL_COLOR = 8'h07
) (
    input  logic                 video_clock,
    input  logic                 reset,
    kftvga_text_writer_if.slave  host,
    input  logic                 clear_request,
    output logic                 vram_write_enable,
    output logic [12:0]          vram_write_address,
    output logic [15:0]          vram_write_data,
    output logic [12:0]          vram_read_address,
    input  logic [15:0]          vram_read_data,
    output logic [6:0]           cursor_column,
    output logic [5:0]           cursor_row,
    output logic                 busy
);
    localparam logic [6:0]  LAST_COL   = 7'(COLUMNS - 1);
    localparam logic [5:0]  LAST_ROW   = 6'(ROWS - 1);
    localparam logic [12:0] ROW_WORDS  = 13'(COLUMNS);
    localparam logic [12:0] LAST_CELL  = 13'(COLUMNS * ROWS - 1);
    localparam logic [12:0] COPY_WORDS = 13'(COLUMNS * (ROWS - 1));
    localparam logic [15:0] FILL_WORD  = {FILL_COLOR, FILL_CODE};

    typedef enum logic [2:0] {IDLE, WRITE, SCROLL_COPY, SCROLL_FILL, CLEAR} state_t;

    state_t      state_q, state_d;
    logic [6:0]  column_q, column_d;
    logic [5:0]  row_q, row_d;
    logic [12:0] index_q, index_d;
    logic [12:0] read_addr_q, read_addr_d;
    logic        wr_en_q, wr_en_d;
    logic [12:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        copy_pass_q, copy_pass_d;
    logic        scroll_pending_q, scroll_pending_d;
    logic        accept;
    logic        start_clear;
    logic        start_copy;
    logic [12:0] cell_addr;

    assign host.char_ready = (state_q == IDLE) && !clear_request && !reset;
    assign accept          = host.char_valid && host.char_ready;
    // row*80 as shift-add; tied to the 80-column layout
    assign cell_addr = (13'(row_q) << 6) + (13'(row_q) << 4) + 13'(column_q);

    always_comb begin
        state_d          = state_q;
        column_d         = column_q;
        row_d            = row_q;
        index_d          = index_q;
        read_addr_d      = read_addr_q;
        wr_en_d          = 1'b0;
        wr_addr_d        = wr_addr_q;
        wr_data_d        = wr_data_q;
        copy_pass_d      = 1'b0;
        scroll_pending_d = scroll_pending_q;
        start_clear      = 1'b0;
        start_copy       = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear_request) begin
                    start_clear = 1'b1;
                end else if (accept) begin
                    case (host.char_code)
                        8'h0D: column_d = '0;
                        8'h0A: begin
                            if (row_q < LAST_ROW) row_d = row_q + 6'd1;
                            else                  start_copy = 1'b1;
                        end
                        8'h08: if (column_q != '0) column_d = column_q - 7'd1;
                        8'h0C: start_clear = 1'b1;
                        default: begin
                            state_d   = WRITE;
                            wr_en_d   = 1'b1;
                            wr_addr_d = cell_addr;
                            wr_data_d = {host.char_color, host.char_code};
                            if (column_q < LAST_COL) begin
                                column_d = column_q + 7'd1;
                            end else begin
                                column_d = '0;
                                if (row_q < LAST_ROW) row_d = row_q + 6'd1;
                                else                  scroll_pending_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            WRITE: begin
                scroll_pending_d = 1'b0;
                if (scroll_pending_q) start_copy = 1'b1;
                else                  state_d = IDLE;
            end
            SCROLL_COPY: begin
                // Write data is the RAM output word, which arrives in the same
                // cycle as the write strobe issued for the previous read.
                if (index_q == COPY_WORDS) begin
                    state_d   = SCROLL_FILL;
                    index_d   = '0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = COPY_WORDS;
                    wr_data_d = FILL_WORD;
                end else begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = index_q;
                    copy_pass_d = 1'b1;
                    index_d     = index_q + 13'd1;
                    if (read_addr_q != LAST_CELL) read_addr_d = read_addr_q + 13'd1;
                end
            end
            SCROLL_FILL: begin
                if (index_q == ROW_WORDS - 13'd1) begin
                    state_d = IDLE;
                end else begin
                    index_d   = index_q + 13'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = COPY_WORDS + index_q + 13'd1;
                    wr_data_d = FILL_WORD;
                end
            end
            CLEAR: begin
                if (index_q == LAST_CELL) begin
                    state_d = IDLE;
                end else begin
                    index_d   = index_q + 13'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = index_q + 13'd1;
                    wr_data_d = FILL_WORD;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_clear) begin
            state_d   = CLEAR;
            column_d  = '0;
            row_d     = '0;
            index_d   = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = FILL_WORD;
        end
        if (start_copy) begin
            state_d     = SCROLL_COPY;
            index_d     = '0;
            read_addr_d = ROW_WORDS;
        end
    end

    always_ff @(posedge video_clock) begin
        if (reset) begin
            state_q          <= IDLE;
            column_q         <= '0;
            row_q            <= '0;
            index_q          <= '0;
            read_addr_q      <= '0;
            wr_en_q          <= 1'b0;
            wr_addr_q        <= '0;
            wr_data_q        <= '0;
            copy_pass_q      <= 1'b0;
            scroll_pending_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            column_q         <= column_d;
            row_q            <= row_d;
            index_q          <= index_d;
            read_addr_q      <= read_addr_d;
            wr_en_q          <= wr_en_d;
            wr_addr_q        <= wr_addr_d;
            wr_data_q        <= wr_data_d;
            copy_pass_q      <= copy_pass_d;
            scroll_pending_q <= scroll_pending_d;
        end
    end

    assign vram_write_enable  = wr_en_q;
    assign vram_write_address = wr_addr_q;
    assign vram_write_data    = copy_pass_q ? vram_read_data : wr_data_q;
    assign vram_read_address  = read_addr_q;
    assign cursor_column      = column_q;
    assign cursor_row         = row_q;
    assign busy               = (state_q != IDLE);
endmodule

// File: tb/tb_kftvga_text_writer.sv
// Bench for kftvga_text_writer: synchronous VRAM model, write log and a
// screen-level reference model of cursor and VRAM contents.
module tb_kftvga_text_writer;
    logic        clk;
    logic        reset;
    logic        clear_request;
    logic        wen;
    logic [12:0] waddr;
    logic [15:0] wdata;
    logic [12:0] raddr;
    logic [15:0] rdata;
    logic [6:0]  col;
    logic [5:0]  row;
    logic        busy;

    kftvga_text_writer_if host_if ();

    kftvga_text_writer #(
        .COLUMNS   (80),
        .ROWS      (60),
        .FILL_CODE (8'h20),
        .FILL_COLOR(8'h07)
    ) dut (
        .video_clock       (clk),
        .reset             (reset),
        .host              (host_if),
        .clear_request     (clear_request),
        .vram_write_enable (wen),
        .vram_write_address(waddr),
        .vram_write_data   (wdata),
        .vram_read_address (raddr),
        .vram_read_data    (rdata),
        .cursor_column     (col),
        .cursor_row        (row),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [4800];
    logic [15:0] ref_mem [4800];
    logic [28:0] wr_log [$];
    int unsigned bad_raddr = 0;
    int unsigned bad_waddr = 0;
    logic        mem_init;
    logic [15:0] salt;
    int          ref_col;
    int          ref_row;
    int          tests = 0;
    int          failed = 0;

    function automatic logic [15:0] pattern(input int i);
        return 16'(i * 40503 + 977) ^ salt;
    endfunction

    // Synchronous-read VRAM plus a log of every write strobe seen.
    always @(posedge clk) begin
        if (!reset) begin
            if (raddr < 13'd4800) rdata <= mem[raddr];
            else begin rdata <= 16'hDEAD; bad_raddr <= bad_raddr + 1; end
        end
        if (mem_init) begin
            for (int i = 0; i < 4800; i++) mem[i] <= pattern(i);
        end else if (wen) begin
            if (waddr < 13'd4800) mem[waddr] <= wdata;
            else bad_waddr <= bad_waddr + 1;
            wr_log.push_back({waddr, wdata});
        end
    end

    task automatic model_scroll();
        for (int i = 0; i < 4720; i++) ref_mem[i] = ref_mem[i + 80];
        for (int i = 4720; i < 4800; i++) ref_mem[i] = 16'h0720;
    endtask

    task automatic model_apply(input logic [7:0] code, input logic [7:0] color);
        case (code)
            8'h0D: ref_col = 0;
            8'h0A: if (ref_row < 59) ref_row++; else model_scroll();
            8'h08: if (ref_col > 0) ref_col--;
            8'h0C: begin
                for (int i = 0; i < 4800; i++) ref_mem[i] = 16'h0720;
                ref_col = 0;
                ref_row = 0;
            end
            default: begin
                ref_mem[ref_row * 80 + ref_col] = {color, code};
                ref_col++;
                if (ref_col == 80) begin
                    ref_col = 0;
                    if (ref_row < 59) ref_row++; else model_scroll();
                end
            end
        endcase
    endtask

    function automatic logic [7:0] rand_printable();
        return 8'($urandom_range(8'h21, 8'h7E));
    endfunction

    // Present one code, wait (bounded) for acceptance; returns at the
    // falling edge right after the accepting rising edge.
    task automatic send(input logic [7:0] code, input logic [7:0] color);
        int unsigned n;
        n = 0;
        host_if.char_valid = 1'b1;
        host_if.char_code  = code;
        host_if.char_color = color;
        while (host_if.char_ready !== 1'b1 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10000) begin
            tests++; failed++;
            $display("FAIL send_timeout: char_ready=%b required 1", host_if.char_ready);
        end
        @(negedge clk);
        host_if.char_valid = 1'b0;
        model_apply(code, color);
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while ((busy !== 1'b0 || host_if.char_ready !== 1'b1) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10000) begin
            tests++; failed++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({wen, waddr, wdata, raddr, busy, col, row} !== '0) begin
            failed++;
            $display("FAIL reset_outputs: wen=%b waddr=%0d wdata=%h raddr=%0d busy=%b col=%0d row=%0d required all 0",
                     wen, waddr, wdata, raddr, busy, col, row);
        end
        tests++;
        if (host_if.char_ready !== 1'b0) begin
            failed++; $display("FAIL reset_ready_low: got %b required 0", host_if.char_ready);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (host_if.char_ready !== 1'b1) begin
            failed++; $display("FAIL reset_ready_release: got %b required 1", host_if.char_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_first_char();
        int unsigned mark;
        mark = wr_log.size();
        host_if.char_valid = 1'b1;
        host_if.char_code  = 8'h41;
        host_if.char_color = 8'h1E;
        tests++;
        if (host_if.char_ready !== 1'b1) begin
            failed++; $display("FAIL first_ready: got %b required 1", host_if.char_ready);
        end
        @(negedge clk);
        host_if.char_valid = 1'b0;
        model_apply(8'h41, 8'h1E);
        tests++;
        if ({wen, waddr, wdata} !== {1'b1, 13'd0, 16'h1E41}) begin
            failed++; $display("FAIL first_write: wen=%b addr=%0d data=%h required 1/0/1e41", wen, waddr, wdata);
        end
        tests++;
        if ({col, row} !== {7'd1, 6'd0}) begin
            failed++; $display("FAIL first_cursor: got (%0d,%0d) required (1,0)", col, row);
        end
        tests++;
        if ({host_if.char_ready, busy} !== 2'b01) begin
            failed++; $display("FAIL first_ready_gap: ready=%b busy=%b required 0/1", host_if.char_ready, busy);
        end
        @(negedge clk);
        tests++;
        if ({wen, host_if.char_ready, busy} !== 3'b010) begin
            failed++; $display("FAIL first_return: wen=%b ready=%b busy=%b required 0/1/0", wen, host_if.char_ready, busy);
        end
        tests++;
        if (wr_log.size() - mark != 1) begin
            failed++; $display("FAIL first_count: got %0d writes required 1", wr_log.size() - mark);
        end
    endtask

    task automatic test_bs_cr();
        int unsigned mark;
        repeat (3) send(8'h0A, 8'h00);
        send(8'h08, 8'h00);
        mark = wr_log.size();
        send(8'h08, 8'h00);
        tests++;
        if ({col, row, host_if.char_ready} !== {7'd0, 6'd3, 1'b1}) begin
            failed++; $display("FAIL bs_at_col0: got (%0d,%0d) ready=%b required (0,3) ready=1", col, row, host_if.char_ready);
        end
        repeat (5) send(rand_printable(), 8'($urandom));
        wait_idle();
        mark = wr_log.size();
        send(8'h58, 8'h2A);
        wait_idle();
        tests++;
        if (wr_log.size() - mark != 1 || wr_log[mark] !== {13'd245, 16'h2A58}) begin
            failed++; $display("FAIL x_write: got %0d writes first=%h required 1 write %h", wr_log.size() - mark, wr_log[mark], {13'd245, 16'h2A58});
        end
        send(8'h0D, 8'h00);
        tests++;
        if ({col, row} !== {7'd0, 6'd3} || wr_log.size() - mark != 1) begin
            failed++; $display("FAIL cr_cursor: got (%0d,%0d) writes=%0d required (0,3) writes=1", col, row, wr_log.size() - mark);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned mark;
        repeat (4) send(rand_printable(), 8'($urandom));
        wait_idle();
        mark = wr_log.size();
        host_if.char_valid = 1'b1;
        host_if.char_code  = 8'h08;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            model_apply(8'h08, 8'h00);
            tests++;
            if (col !== 7'(ref_col) || host_if.char_ready !== 1'b1) begin
                failed++; $display("FAIL b2b_bs_%0d: col=%0d ready=%b required col=%0d ready=1", k, col, host_if.char_ready, ref_col);
            end
        end
        host_if.char_valid = 1'b0;
        tests++;
        if (wr_log.size() != mark) begin
            failed++; $display("FAIL b2b_no_write: got %0d writes required 0", wr_log.size() - mark);
        end
    endtask

    task automatic test_wrap();
        int unsigned mark;
        send(8'h0A, 8'h00);
        send(8'h0A, 8'h00);
        send(8'h0D, 8'h00);
        repeat (79) send(rand_printable(), 8'($urandom));
        wait_idle();
        tests++;
        if ({col, row} !== {7'd79, 6'd5}) begin
            failed++; $display("FAIL wrap_setup: got (%0d,%0d) required (79,5)", col, row);
        end
        mark = wr_log.size();
        send(8'h42, 8'h07);
        wait_idle();
        tests++;
        if (wr_log.size() - mark != 1 || wr_log[mark] !== {13'd479, 16'h0742}) begin
            failed++; $display("FAIL wrap_write: got %0d writes first=%h required 1 write %h", wr_log.size() - mark, wr_log[mark], {13'd479, 16'h0742});
        end
        tests++;
        if ({col, row} !== {7'd0, 6'd6}) begin
            failed++; $display("FAIL wrap_cursor: got (%0d,%0d) required (0,6)", col, row);
        end
    endtask

    task automatic test_random_stream();
        int bad;
        int first;
        logic [7:0] code;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 15))
                0:       code = 8'h0D;
                1:       code = 8'h08;
                2:       code = (ref_row < 59) ? 8'h0A : 8'h0D;
                default: code = (ref_row == 59 && ref_col == 79) ? 8'h0D : rand_printable();
            endcase
            send(code, 8'($urandom));
        end
        wait_idle();
        tests++;
        if (col !== 7'(ref_col) || row !== 6'(ref_row)) begin
            failed++; $display("FAIL random_cursor: got (%0d,%0d) required (%0d,%0d)", col, row, ref_col, ref_row);
        end
        bad = 0; first = 0;
        for (int i = 0; i < 4800; i++) if (mem[i] !== ref_mem[i]) begin if (bad == 0) first = i; bad++; end
        tests++;
        if (bad != 0) begin
            failed++; $display("FAIL random_screen: %0d cells differ, cell %0d got %h required %h", bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic test_scroll();
        int unsigned mark;
        int unsigned cycles;
        int bad;
        int first;
        logic [15:0] old80, old4799;
        send(8'h0D, 8'h00);
        while (ref_row < 59) send(8'h0A, 8'h00);
        repeat (10) send(rand_printable(), 8'($urandom));
        wait_idle();
        tests++;
        if ({col, row} !== {7'd10, 6'd59}) begin
            failed++; $display("FAIL scroll_setup: got (%0d,%0d) required (10,59)", col, row);
        end
        old80   = ref_mem[80];
        old4799 = ref_mem[4799];
        mark = wr_log.size();
        host_if.char_valid = 1'b1;
        host_if.char_code  = 8'h0A;
        @(negedge clk);
        host_if.char_valid = 1'b0;
        model_apply(8'h0A, 8'h00);
        cycles = 0;
        while (busy === 1'b1 && cycles < 6000) begin
            if (cycles == 0) begin
                tests++;
                if (raddr !== 13'd80 || wen !== 1'b0) begin
                    failed++; $display("FAIL scroll_first_read: raddr=%0d wen=%b required 80/0", raddr, wen);
                end
            end
            if (cycles == 1) begin
                tests++;
                if ({wen, waddr, raddr} !== {1'b1, 13'd0, 13'd81}) begin
                    failed++; $display("FAIL scroll_first_write: wen=%b waddr=%0d raddr=%0d required 1/0/81", wen, waddr, raddr);
                end
            end
            cycles++;
            @(negedge clk);
        end
        tests++;
        if (cycles != 4801) begin
            failed++; $display("FAIL scroll_busy: got %0d cycles required 4801", cycles);
        end
        tests++;
        if (wr_log.size() - mark != 4800) begin
            failed++; $display("FAIL scroll_count: got %0d writes required 4800", wr_log.size() - mark);
        end else begin
            bad = 0; first = 0;
            for (int i = 0; i < 4800; i++)
                if (wr_log[mark + i] !== {13'(i), ref_mem[i]}) begin if (bad == 0) first = i; bad++; end
            tests++;
            if (bad != 0) begin
                failed++; $display("FAIL scroll_writes: %0d differ, write %0d got %h required %h", bad, first, wr_log[mark + first], {13'(first), ref_mem[first]});
            end
            tests++;
            if (wr_log[mark][15:0] !== old80 || wr_log[mark + 4719] !== {13'd4719, old4799}) begin
                failed++; $display("FAIL scroll_ends: first=%h last=%h required data %h and %h", wr_log[mark], wr_log[mark + 4719], old80, old4799);
            end
        end
        tests++;
        if ({col, row, host_if.char_ready} !== {7'd10, 6'd59, 1'b1}) begin
            failed++; $display("FAIL scroll_cursor: got (%0d,%0d) ready=%b required (10,59) ready=1", col, row, host_if.char_ready);
        end
        bad = 0; first = 0;
        for (int i = 0; i < 4800; i++) if (mem[i] !== ref_mem[i]) begin if (bad == 0) first = i; bad++; end
        tests++;
        if (bad != 0) begin
            failed++; $display("FAIL scroll_screen: %0d cells differ, cell %0d got %h required %h", bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic test_clear();
        int unsigned mark;
        int unsigned cycles;
        int bad;
        mark = wr_log.size();
        clear_request      = 1'b1;
        host_if.char_valid = 1'b1;
        host_if.char_code  = 8'h5A;
        host_if.char_color = 8'h4F;
        #1;
        tests++;
        if (host_if.char_ready !== 1'b0) begin
            failed++; $display("FAIL clear_blocks_ready: got %b required 0", host_if.char_ready);
        end
        @(negedge clk);
        clear_request      = 1'b0;
        host_if.char_valid = 1'b0;
        model_apply(8'h0C, 8'h00);
        cycles = 0;
        while (busy === 1'b1 && cycles < 6000) begin
            cycles++;
            @(negedge clk);
        end
        tests++;
        if (cycles != 4800) begin
            failed++; $display("FAIL clear_busy: got %0d cycles required 4800", cycles);
        end
        bad = 0;
        if (wr_log.size() - mark == 4800)
            for (int i = 0; i < 4800; i++) if (wr_log[mark + i] !== {13'(i), 16'h0720}) bad++;
        tests++;
        if (wr_log.size() - mark != 4800 || bad != 0) begin
            failed++; $display("FAIL clear_writes: got %0d writes with %0d wrong required 4800 of 0720 ascending", wr_log.size() - mark, bad);
        end
        tests++;
        if ({col, row} !== {7'd0, 6'd0}) begin
            failed++; $display("FAIL clear_cursor: got (%0d,%0d) required (0,0)", col, row);
        end
    endtask

    task automatic test_reset_mid_clear();
        int unsigned mark;
        int bad;
        int first;
        repeat (3) send(rand_printable(), 8'($urandom));
        wait_idle();
        mark = wr_log.size();
        host_if.char_valid = 1'b1;
        host_if.char_code  = 8'h0C;
        @(negedge clk);
        host_if.char_valid = 1'b0;
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({wen, busy, col, row} !== '0) begin
            failed++; $display("FAIL abort_state: wen=%b busy=%b col=%0d row=%0d required all 0", wen, busy, col, row);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (host_if.char_ready !== 1'b1) begin
            failed++; $display("FAIL abort_ready: got %b required 1", host_if.char_ready);
        end
        @(negedge clk);
        for (int i = 0; i <= 100; i++) ref_mem[i] = 16'h0720;
        ref_col = 0;
        ref_row = 0;
        bad = 0;
        if (wr_log.size() - mark == 101)
            for (int i = 0; i <= 100; i++) if (wr_log[mark + i] !== {13'(i), 16'h0720}) bad++;
        tests++;
        if (wr_log.size() - mark != 101 || bad != 0 || busy !== 1'b0) begin
            failed++; $display("FAIL abort_writes: got %0d writes (%0d wrong) busy=%b required 101 writes busy=0", wr_log.size() - mark, bad, busy);
        end
        bad = 0; first = 0;
        for (int i = 0; i < 4800; i++) if (mem[i] !== ref_mem[i]) begin if (bad == 0) first = i; bad++; end
        tests++;
        if (bad != 0) begin
            failed++; $display("FAIL abort_screen: %0d cells differ, cell %0d got %h required %h", bad, first, mem[first], ref_mem[first]);
        end
        tests++;
        if (bad_raddr != 0 || bad_waddr != 0) begin
            failed++; $display("FAIL address_range: %0d reads and %0d writes beyond 4799 required 0", bad_raddr, bad_waddr);
        end
    endtask

    initial begin
        reset              = 1'b1;
        clear_request      = 1'b0;
        host_if.char_valid = 1'b0;
        host_if.char_code  = 8'h00;
        host_if.char_color = 8'h00;
        salt               = 16'($urandom);
        mem_init           = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
        for (int i = 0; i < 4800; i++) ref_mem[i] = pattern(i);
        ref_col = 0;
        ref_row = 0;

        test_reset();
        test_first_char();
        test_bs_cr();
        test_back_to_back();
        test_wrap();
        test_random_stream();
        test_scroll();
        test_clear();
        test_reset_mid_clear();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/kftvga_text_writer.md
# kftvga_text_writer

Host-side writer for the 80x60 text-mode VRAM scanned by the VGA video controller. It accepts a stream of character/colour bytes over a valid/ready handshake and writes them into VRAM at a hardware cursor. It also handles CR, LF, BS and FF control codes, line wrap, hardware scroll and full-screen clear. It owns the VRAM write port and a read port used only for scrolling. VRAM word layout is {color[7:0], code[7:0]}, with colour high nibble = background and low nibble = foreground.

## Interface
- COLUMNS, 80, characters per row
- ROWS, 60, rows per screen
- FILL_CODE, 8'h20, character written by clear/scroll fill
- FILL_COLOR, 8'h07, colour written by clear/scroll fill
- video_clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- char_valid  in  1  host presents a character
- char_ready  out  1  writer accepts; transfer when valid && ready on a rising edge
- char_code  in  8  character / control code
- char_color  in  8  colour attribute for printable codes
- clear_request  in  1  level; sampled only in IDLE; clears the screen and homes the cursor
- vram_write_enable  out  1  one-cycle write strobe
- vram_write_address  out  13  cell address = row*80 + column
- vram_write_data  out  16  {color, code}
- vram_read_address  out  13  scroll source address
- vram_read_data  in  16  VRAM word; valid 1 cycle after address (synchronous RAM)
- cursor_column  out  7  0..79
- cursor_row  out  6  0..59
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WRITE, SCROLL_COPY, SCROLL_FILL, CLEAR.
- char_ready = (state == IDLE) && !clear_request && !reset, combinational.
- IDLE with clear_request=1: go to CLEAR. Clear has priority over a simultaneous char_valid, and that character is not accepted.
- Accepted code 0x0D (CR): column <= 0; stay IDLE; no VRAM write.
- Accepted code 0x0A (LF): if row < 59, row+1 and stay IDLE. If row == 59, go to SCROLL_COPY; the column is unchanged in both cases.
- Accepted code 0x08 (BS): column-1 if column > 0, else no change. No write.
- Accepted code 0x0C (FF): same as clear_request; go to CLEAR.
- Any other code: go to WRITE.
  - Register address = row*80 + column, computed as (row<<6)+(row<<4)+column in 13 bits, with data {char_color, char_code}.
  - If column < 79: column+1.
  - If column == 79: column <= 0; then row+1 if row < 59, else next state is SCROLL_COPY instead of IDLE.
- SCROLL_COPY: read index runs 80..4799, one per cycle. Each returned word is written to (index − 80) one cycle later. This moves rows 1..59 up to rows 0..58.
- SCROLL_FILL: writes {FILL_COLOR, FILL_CODE} to addresses 4720..4799, then returns to IDLE.
- CLEAR: writes the fill word to addresses 0..4799 in ascending order, then returns to IDLE with cursor (0,0).
- Cursor values never leave 0..79 / 0..59. Addresses never exceed 4799.

## Timing
- Reset values: state IDLE, cursor 0/0, vram_write_enable 0, vram_write_address 0, vram_write_data 0, vram_read_address 0, busy 0.
- Reset asserted in any state aborts the operation at that edge: no further writes occur and VRAM contents are left as-is.
- Printable character accepted at edge N:
  - vram_write_enable = 1 during cycle N+1 only.
  - Cursor is updated at edge N.
  - char_ready returns at cycle N+2 (throughput 1 char / 2 cycles).
- CR/LF-without-scroll/BS: cursor updates at the accept edge; char_ready stays high, so back-to-back acceptance is allowed.
- SCROLL_COPY:
  - Read addresses 80..4799 are presented on 4720 consecutive cycles.
  - Write enable lags the first read by exactly 1 cycle, with write address = previous read address − 80.
  - Total 4721 cycles, followed by 80 SCROLL_FILL cycles.
- CLEAR: 4800 consecutive write cycles. busy is high for exactly those cycles.
- vram_write_* outputs are registered. Outside write cycles, vram_write_enable is low; address and data hold their last values.

## Test plan
- Reset, then send 'A' (0x41, colour 0x1E) → one write, addr 0, data 0x1E41; cursor (1,0); char_ready low for exactly 1 cycle.
- Place cursor at (79,5), send 'B' colour 0x07 → write addr 479, data 0x0742; cursor (0,6); no scroll.
- Cursor (10,59), send LF → 4720 copy writes (first is addr 0 ← read 80, last is addr 4719 ← read 4799), then 80 writes of 0x0720 at 4720..4799; cursor (10,59); busy 4801 cycles.
- Assert clear_request and char_valid together in IDLE → char not accepted; 4800 writes of 0x0720 at 0..4799; cursor (0,0).
- Cursor (0,3): send BS → cursor (0,3), no write; send CR after 'X' at (5,3) → cursor (0,3).
- Assert reset at cycle 100 of CLEAR → no writes after that edge; busy 0, cursor (0,0), char_ready 1 on the first cycle after reset deasserts.
